// File: rtl/command_decoder_mc_if.sv
// Frame input and frame-buffer/status output bundle for command_decoder_mc.
// The SPI side acts as master; the decoder is the slave.
interface command_decoder_mc_if #(
  parameter int ROW_W   = 5,
  parameter int COL_W   = 5,
  parameter int SCORE_W = 10
);
  localparam int ADDR_W = ROW_W + COL_W;

  logic               spi_done;
  logic [7:0]         command;
  logic [7:0]         databyte1;
  logic [7:0]         databyte2;
  logic               we;
  logic [ADDR_W-1:0]  waddr;
  logic [7:0]         wdata;
  logic [SCORE_W-1:0] score;
  logic               clrcmd;
  logic               busy;
  logic               overrun;

  modport master (
    output spi_done, command, databyte1, databyte2,
    input  we, waddr, wdata, score, clrcmd, busy, overrun
  );

  modport slave (
    input  spi_done, command, databyte1, databyte2,
    output we, waddr, wdata, score, clrcmd, busy, overrun
  );
endinterface

// File: rtl/command_decoder_mc.sv
// Decodes complete SPI frames into score updates and frame-buffer writes,
// including multi-cycle row and full-screen fills.
module command_decoder_mc #(
  parameter int COL_W   = 5,
  parameter int ROW_W   = 5,
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 32,
  parameter int COLOR_W = 3,
  parameter int SCORE_W = 10
) (
  input  logic clk,
  input  logic reset,
  command_decoder_mc_if.slave bus
);
  localparam logic [3:0] OP_SCORE    = 4'h1;
  localparam logic [3:0] OP_WRITE    = 4'h2;
  localparam logic [3:0] OP_FILL_ROW = 4'h3;
  localparam logic [3:0] OP_FILL_ALL = 4'h4;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_q;
  logic               we_q, clrcmd_q, busy_q, overrun_q;
  logic [ROW_W-1:0]   row_q, row_end_q;
  logic [COL_W-1:0]   col_q;
  logic [7:0]         wdata_q;
  logic [SCORE_W-1:0] score_q;

  logic               accept, drop, row_ok, col_ok, col_last, fill_done;
  logic [3:0]         op;
  logic [7:0]         color;
  logic [15:0]        frame_word;

  always_comb begin
    op         = bus.command[7:4];
    color      = {{(8-COLOR_W){1'b0}}, bus.command[COLOR_W-1:0]};
    frame_word = {bus.databyte1, bus.databyte2};
    // Range checks use the whole byte so high bits beyond ROW_W/COL_W
    // cannot alias an out-of-range index onto a valid cell.
    row_ok     = 32'(bus.databyte1) < 32'(GRID_H);
    col_ok     = 32'(bus.databyte2) < 32'(GRID_W);
    // A level-held frame is masked while clrcmd is up so it decodes once.
    accept     = bus.spi_done && !clrcmd_q && (state_q == IDLE);
    drop       = bus.spi_done && !clrcmd_q && (state_q == FILL);
    col_last   = col_q == COL_W'(GRID_W - 1);
    fill_done  = col_last && (row_q == row_end_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      row_end_q <= '0;
      wdata_q   <= '0;
      score_q   <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      clrcmd_q  <= 1'b1;
    end else begin
      clrcmd_q <= accept | drop;
      we_q     <= 1'b0;
      if (drop) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_SCORE: score_q <= frame_word[SCORE_W-1:0];
              OP_WRITE: begin
                if (row_ok && col_ok) begin
                  we_q    <= 1'b1;
                  row_q   <= bus.databyte1[ROW_W-1:0];
                  col_q   <= bus.databyte2[COL_W-1:0];
                  wdata_q <= color;
                end
              end
              OP_FILL_ROW: begin
                if (row_ok) begin
                  state_q   <= FILL;
                  we_q      <= 1'b1;
                  busy_q    <= 1'b1;
                  row_q     <= bus.databyte1[ROW_W-1:0];
                  row_end_q <= bus.databyte1[ROW_W-1:0];
                  col_q     <= '0;
                  wdata_q   <= color;
                end
              end
              OP_FILL_ALL: begin
                state_q   <= FILL;
                we_q      <= 1'b1;
                busy_q    <= 1'b1;
                row_q     <= '0;
                row_end_q <= ROW_W'(GRID_H - 1);
                col_q     <= '0;
                wdata_q   <= color;
              end
              default: ;
            endcase
          end
        end
        FILL: begin
          // The address registers already hold the cell written this cycle.
          if (fill_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            we_q <= 1'b1;
            if (col_last) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.we      = we_q;
  assign bus.waddr   = {row_q, col_q};
  assign bus.wdata   = wdata_q;
  assign bus.score   = score_q;
  assign bus.clrcmd  = clrcmd_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_command_decoder_mc.sv
// Bench for command_decoder_mc: a 32x32 instance and a 20x15 instance,
// table-driven single-cycle frames plus fill/overrun/reset sequences.
module tb_command_decoder_mc;
  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  command_decoder_mc_if #(.ROW_W(5), .COL_W(5), .SCORE_W(10)) bus0 ();
  command_decoder_mc_if #(.ROW_W(5), .COL_W(5), .SCORE_W(10)) bus1 ();

  command_decoder_mc u_dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  command_decoder_mc #(.GRID_W(20), .GRID_H(15)) u_dut1 (.clk(clk), .reset(rst1), .bus(bus1));

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
    logic       b;
  } wr_t;

  typedef struct {
    logic [7:0] cmd, d1, d2;
    logic       we;
    logic [9:0] waddr;
    logic [7:0] wdata;
    logic [9:0] score;
  } vec_t;

  typedef struct {
    logic       we, clr, busy, ovr;
    logic [9:0] waddr;
    logic [7:0] wdata;
    logic [9:0] score;
  } out_t;

  wr_t  q0[$], q1[$];
  wr_t  e0, e1;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic out_t get(input int sel);
    out_t o;
    if (sel == 0) begin
      o.we = bus0.we; o.clr = bus0.clrcmd; o.busy = bus0.busy; o.ovr = bus0.overrun;
      o.waddr = bus0.waddr; o.wdata = bus0.wdata; o.score = bus0.score;
    end else begin
      o.we = bus1.we; o.clr = bus1.clrcmd; o.busy = bus1.busy; o.ovr = bus1.overrun;
      o.waddr = bus1.waddr; o.wdata = bus1.wdata; o.score = bus1.score;
    end
    return o;
  endfunction

  task automatic drive(input int sel, input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
    if (sel == 0) begin
      bus0.spi_done = 1'b1; bus0.command = c; bus0.databyte1 = a; bus0.databyte2 = b;
    end else begin
      bus1.spi_done = 1'b1; bus1.command = c; bus1.databyte1 = a; bus1.databyte2 = b;
    end
  endtask

  task automatic drop_frame(input int sel);
    if (sel == 0) bus0.spi_done = 1'b0;
    else          bus1.spi_done = 1'b0;
  endtask

  task automatic push(input int sel, input logic [9:0] a, input logic [7:0] d, input logic b);
    wr_t w;
    w.a = a; w.d = d; w.b = b;
    if (sel == 0) q0.push_back(w);
    else          q1.push_back(w);
  endtask

  // Expected write stream for a fill over rows r0..r1 of a w-wide grid.
  task automatic push_fill(input int sel, input int r0, input int r1, input int w, input logic [7:0] d);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < w; c++)
        push(sel, 10'((r << 5) | c), d, 1'b1);
  endtask

  task automatic wait_left(input int sel, input int left, input int budget);
    int n;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      n = (sel == 0) ? q0.size() : q1.size();
      if (n <= left) begin ok = 1'b1; break; end
    end
    if (!ok) chk($sformatf("dut%0d write budget", sel), 32'(n), 32'(left));
  endtask

  task automatic apply(input int sel, input vec_t v);
    out_t o;
    if (v.we) push(sel, v.waddr, v.wdata, 1'b0);
    @(posedge clk); #1; drive(sel, v.cmd, v.d1, v.d2);
    @(posedge clk); #1; drop_frame(sel);
    @(negedge clk);
    o = get(sel);
    chk("clrcmd pulse", 32'(o.clr), 1);
    chk("we", 32'(o.we), 32'(v.we));
    chk("waddr", 32'(o.waddr), 32'(v.waddr));
    chk("wdata", 32'(o.wdata), 32'(v.wdata));
    chk("score", 32'(o.score), 32'(v.score));
    chk("busy idle", 32'(o.busy), 0);
    @(negedge clk);
    o = get(sel);
    chk("clrcmd single", 32'(o.clr), 0);
  endtask

  // Every write is popped against the scoreboard; any extra write is an error.
  always @(negedge clk) begin
    if (bus0.we === 1'b1) begin
      if (q0.size() == 0) chk("dut0 unexpected write", 32'(bus0.waddr), 32'h3ff_ffff);
      else begin
        e0 = q0.pop_front();
        chk("dut0 wr addr", 32'(bus0.waddr), 32'(e0.a));
        chk("dut0 wr data", 32'(bus0.wdata), 32'(e0.d));
        chk("dut0 wr busy", 32'(bus0.busy), 32'(e0.b));
      end
    end else if (bus0.busy === 1'b1) chk("dut0 busy without we", 32'(bus0.we), 1);
  end

  always @(negedge clk) begin
    if (bus1.we === 1'b1) begin
      if (q1.size() == 0) chk("dut1 unexpected write", 32'(bus1.waddr), 32'h3ff_ffff);
      else begin
        e1 = q1.pop_front();
        chk("dut1 wr addr", 32'(bus1.waddr), 32'(e1.a));
        chk("dut1 wr data", 32'(bus1.wdata), 32'(e1.d));
        chk("dut1 wr busy", 32'(bus1.busy), 32'(e1.b));
      end
    end else if (bus1.busy === 1'b1) chk("dut1 busy without we", 32'(bus1.we), 1);
  end

  initial begin
    out_t o;
    tbl[0] = '{8'h10, 8'h02, 8'h5A, 1'b0, 10'h000, 8'h00, 10'h25A};
    tbl[1] = '{8'h25, 8'h03, 8'h07, 1'b1, 10'h067, 8'h05, 10'h25A};
    tbl[2] = '{8'h25, 8'd40, 8'h07, 1'b0, 10'h067, 8'h05, 10'h25A};
    tbl[3] = '{8'h27, 8'h03, 8'd32, 1'b0, 10'h067, 8'h05, 10'h25A};
    tbl[4] = '{8'h00, 8'hFF, 8'hFF, 1'b0, 10'h067, 8'h05, 10'h25A};
    tbl[5] = '{8'h1F, 8'hFF, 8'hFF, 1'b0, 10'h067, 8'h05, 10'h3FF};
    tbl[6] = '{8'h2F, 8'h1F, 8'h1F, 1'b1, 10'h3FF, 8'h07, 10'h3FF};
    tbl[7] = '{8'h33, 8'd32, 8'h00, 1'b0, 10'h3FF, 8'h07, 10'h3FF};
    tbl[8] = '{8'h5A, 8'h01, 8'h01, 1'b0, 10'h3FF, 8'h07, 10'h3FF};
    tbl[9] = '{8'h21, 8'h00, 8'h00, 1'b1, 10'h000, 8'h01, 10'h3FF};

    bus0.spi_done = 1'b0; bus0.command = '0; bus0.databyte1 = '0; bus0.databyte2 = '0;
    bus1.spi_done = 1'b0; bus1.command = '0; bus1.databyte1 = '0; bus1.databyte2 = '0;
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = get(s);
      chk("rst we", 32'(o.we), 0);
      chk("rst waddr", 32'(o.waddr), 0);
      chk("rst wdata", 32'(o.wdata), 0);
      chk("rst score", 32'(o.score), 0);
      chk("rst busy", 32'(o.busy), 0);
      chk("rst overrun", 32'(o.ovr), 0);
      chk("rst clrcmd", 32'(o.clr), 1);
    end

    for (int i = 0; i < 10; i++) apply(0, tbl[i]);

    // FILL_ROW row 4, then a frame in the very first cycle after the last write.
    push_fill(0, 4, 4, 32, 8'h02);
    @(posedge clk); #1; drive(0, 8'h32, 8'd4, 8'h00);
    @(posedge clk); #1; drop_frame(0);
    @(negedge clk);
    chk("fill_row clrcmd", 32'(bus0.clrcmd), 1);
    wait_left(0, 0, 100);
    @(posedge clk); #1; drive(0, 8'h10, 8'h01, 8'h23);
    @(negedge clk);
    chk("fill_row done busy", 32'(bus0.busy), 0);
    chk("fill_row done we", 32'(bus0.we), 0);
    chk("fill_row hold waddr", 32'(bus0.waddr), 32'h09F);
    chk("fill_row hold wdata", 32'(bus0.wdata), 32'h02);
    @(posedge clk); #1; drop_frame(0);
    @(negedge clk);
    chk("post-fill accept clrcmd", 32'(bus0.clrcmd), 1);
    chk("post-fill accept score", 32'(bus0.score), 32'h123);
    chk("post-fill no overrun", 32'(bus0.overrun), 0);

    // spi_done held through the clrcmd cycle with changed data: one decode only.
    @(posedge clk); #1; drive(0, 8'h10, 8'h00, 8'h11);
    @(posedge clk); #1; bus0.databyte2 = 8'h22;
    @(negedge clk);
    chk("held clrcmd", 32'(bus0.clrcmd), 1);
    chk("held score", 32'(bus0.score), 32'h011);
    @(posedge clk); #1; drop_frame(0);
    @(negedge clk);
    chk("held no redecode clrcmd", 32'(bus0.clrcmd), 0);
    chk("held no redecode score", 32'(bus0.score), 32'h011);

    // Reset in the same cycle as a frame discards the frame.
    @(posedge clk); #1; rst0 = 1'b1; drive(0, 8'h10, 8'h00, 8'h77);
    @(posedge clk); #1; rst0 = 1'b0; drop_frame(0);
    @(negedge clk);
    chk("rst prio score", 32'(bus0.score), 0);
    chk("rst prio clrcmd", 32'(bus0.clrcmd), 1);
    @(negedge clk);
    chk("rst prio score later", 32'(bus0.score), 0);
    chk("rst prio clrcmd later", 32'(bus0.clrcmd), 0);

    // 20x15 instance: FILL_ALL with a dropped SCORE frame midway.
    apply(1, '{8'h10, 8'h01, 8'h55, 1'b0, 10'h000, 8'h00, 10'h155});
    push_fill(1, 0, 14, 20, 8'h04);
    @(posedge clk); #1; drive(1, 8'h44, 8'h00, 8'h00);
    @(posedge clk); #1; drop_frame(1);
    @(negedge clk);
    chk("fill_all clrcmd", 32'(bus1.clrcmd), 1);
    chk("fill_all busy", 32'(bus1.busy), 1);
    wait_left(1, 250, 100);
    @(posedge clk); #1; drive(1, 8'h10, 8'h03, 8'hFF);
    @(posedge clk); #1; drop_frame(1);
    @(negedge clk);
    chk("overrun clrcmd", 32'(bus1.clrcmd), 1);
    chk("overrun flag", 32'(bus1.overrun), 1);
    chk("overrun score kept", 32'(bus1.score), 32'h155);
    chk("overrun busy", 32'(bus1.busy), 1);
    wait_left(1, 0, 400);
    @(negedge clk);
    chk("fill_all done busy", 32'(bus1.busy), 0);
    chk("fill_all last waddr", 32'(bus1.waddr), 32'h1D3);
    chk("fill_all wdata", 32'(bus1.wdata), 32'h04);
    chk("overrun sticky", 32'(bus1.overrun), 1);
    chk("score after fill", 32'(bus1.score), 32'h155);

    // Reset during the 10th write of FILL_ALL aborts the fill.
    push_fill(1, 0, 14, 20, 8'h03);
    @(posedge clk); #1; drive(1, 8'h43, 8'h00, 8'h00);
    @(posedge clk); #1; drop_frame(1);
    wait_left(1, 290, 50);
    rst1 = 1'b1;
    @(posedge clk); #1; rst1 = 1'b0; q1.delete();
    @(negedge clk);
    chk("abort we", 32'(bus1.we), 0);
    chk("abort busy", 32'(bus1.busy), 0);
    chk("abort overrun", 32'(bus1.overrun), 0);
    chk("abort score", 32'(bus1.score), 0);
    chk("abort clrcmd", 32'(bus1.clrcmd), 1);
    chk("abort waddr", 32'(bus1.waddr), 0);
    repeat (20) @(negedge clk);
    chk("abort stays idle", 32'(bus1.busy), 0);
    chk("dut0 queue drained", 32'(q0.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
